neuron_o_backprop: RTL
======================

// Module: neuron_o_backprop
// PURPOSE
//   Backward-pass (training) unit for the 2-input tanh output neuron, in Q8.24 fixed point.
//   Takes the neuron's forward operands, its activation y and the target t.
//   Computes delta = (y - t)*(1 - y^2) and the updated weights and bias.
//   Also computes the error terms delta*w_1 and delta*w_2, using the pre-update weights,
//   for the hidden-layer backprop units.
//   One time-shared Q8.24 multiplier, sequenced by an FSM, one multiply per cycle.
// PARAMETERS
//   WIDTH  32  data word width (signed Q8.24); only 32 is supported
//   FBITS  24  fractional bits; ONE = 1 << FBITS = 32'h0100_0000
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      unit can accept a bundle (combinational: state==IDLE)
//   a_1, a_2   in   WIDTH  neuron inputs from the forward pass
//   w_1, w_2   in   WIDTH  current weights
//   b          in   WIDTH  current bias
//   y          in   WIDTH  neuron activation (tanh output)
//   t          in   WIDTH  target value
//   lr         in   WIDTH  learning rate
//   out_valid  out  1      result bundle valid
//   out_ready  in   1      downstream accepts the result
//   w_1_new, w_2_new, b_new  out  WIDTH  updated parameters
//   delta      out  WIDTH  output-neuron delta
//   err_1, err_2  out  WIDTH  delta*w_1, delta*w_2 (old weights), sent to the hidden layer
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; out_valid=0; all data outputs and internal regs = 0.
//     Takes effect immediately, including mid-computation; the in-flight bundle is discarded.
//   Multiplier: mul(p,q) = (64-bit signed p*q) >>> FBITS, keeping bits [55:24].
//     Truncation, no rounding, no saturation.
//   Add/sub: 32-bit two's complement, wraps on overflow; no saturation anywhere.
//   Accept: at a rising edge with in_valid && in_ready, all eight inputs are registered.
//     e = y - t is registered in the same edge.
//   FSM: one state per cycle, each state doing one multiply (mul) plus at most one add/sub:
//     IDLE      : wait for accept -> MUL_Y2
//     MUL_Y2    : dy = ONE - mul(y, y)
//     MUL_DELTA : delta = mul(e, dy)
//     MUL_G     : g = mul(lr, delta); b_new = b - g
//     MUL_W1    : w_1_new = w_1 - mul(g, a_1)
//     MUL_W2    : w_2_new = w_2 - mul(g, a_2)
//     MUL_P1    : err_1 = mul(delta, w_1)   (registered old w_1)
//     MUL_P2    : err_2 = mul(delta, w_2) -> DONE
//     DONE      : out_valid=1; on out_valid && out_ready -> IDLE
//   Latency: out_valid rises after the 8th rising edge following the accept edge.
//   Throughput with out_ready tied high: one bundle per 10 cycles.
//   Output registers update only inside the FSM; they stay stable from DONE entry until the next accept.
//   Backpressure: in DONE with out_ready=0, all outputs are held; in_ready=0, so in_valid is ignored.
//   Inputs may change freely after the accept edge, since the registered copies are used.
//   out_valid deasserts on the edge after the out handshake.
//   in_ready goes high in the cycle after that edge; the same cycle cannot both deliver and accept.
//   Boundaries:
//     y = t          -> delta=0; weights and bias pass unchanged; err_1=err_2=0.
//     |y| = ONE      -> dy=0, delta=0 (saturated tanh gives zero gradient).
//     Overflow in e, in an update, or in ONE - y^2 wraps silently.
// TESTING
//   1 Basic: y=0x0080_0000, t=0, lr=0x0080_0000, a_1=0x0100_0000, a_2=0,
//     w_1=0x0080_0000, w_2=0xFF00_0000, b=0
//     -> delta=0x0060_0000, b_new=0xFFD0_0000, w_1_new=0x0050_0000, w_2_new=0xFF00_0000,
//        err_1=0x0030_0000, err_2=0xFFA0_0000; out_valid 8 edges after accept.
//   2 Zero error: y=t=0x0040_0000, any weights -> delta=0, err_1=err_2=0, *_new equal to inputs.
//   3 Saturated: y=0x0100_0000, t=0 -> delta=0, parameters unchanged.
//   4 Backpressure: test 1 with out_ready=0 for 5 cycles and in_valid=1 throughout
//     -> outputs stable, in_ready=0, no second accept; release -> IDLE next edge.
//   5 Reset mid-op: assert rst_n=0 while in MUL_W1
//     -> out_valid=0 and all outputs 0 immediately; in_ready=1 after release; fresh bundle gives correct results.
//   6 Back-to-back: out_ready=1, in_valid=1 with two different bundles
//     -> accepts 10 cycles apart; each result matches a scoreboard model of mul/add.

Source files
------------

// File: rtl/neuron_o_backprop.sv
// Backward-pass unit for the 2-input tanh output neuron (Q8.24).
// A single time-shared multiplier is stepped through seven products by an FSM.
// The FSM computes delta = (y - t) * (1 - y^2), the updated bias and weights,
// and the error terms delta*w_1 and delta*w_2 for the hidden layer.
// The error terms use the pre-update weights.
module neuron_o_backprop #(
  parameter int WIDTH = 32,
  parameter int FBITS = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] a_2,
  input  logic [WIDTH-1:0] w_1,
  input  logic [WIDTH-1:0] w_2,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] lr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] w_1_new,
  output logic [WIDTH-1:0] w_2_new,
  output logic [WIDTH-1:0] b_new,
  output logic [WIDTH-1:0] delta,
  output logic [WIDTH-1:0] err_1,
  output logic [WIDTH-1:0] err_2
);

  // Fixed-point 1.0
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-FBITS-1){1'b0}}, 1'b1, {FBITS{1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE,
    S_MUL_Y2,
    S_MUL_DELTA,
    S_MUL_G,
    S_MUL_W1,
    S_MUL_W2,
    S_MUL_P1,
    S_MUL_P2,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Registered copies of the operand bundle, plus e = y - t
  logic [WIDTH-1:0] r_a1;
  logic [WIDTH-1:0] r_a2;
  logic [WIDTH-1:0] r_w1;
  logic [WIDTH-1:0] r_w2;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_lr;
  logic [WIDTH-1:0] r_e;

  // Intermediates: 1 - y^2 and g = lr * delta
  logic [WIDTH-1:0] r_dy;
  logic [WIDTH-1:0] r_g;

  // Result registers
  logic [WIDTH-1:0] r_delta;
  logic [WIDTH-1:0] r_w1_new;
  logic [WIDTH-1:0] r_w2_new;
  logic [WIDTH-1:0] r_b_new;
  logic [WIDTH-1:0] r_err1;
  logic [WIDTH-1:0] r_err2;
  logic             r_out_valid;

  // Datapath and handshake wires
  logic             w_in_ready;
  logic             w_accept;
  logic             w_out_fire;
  logic [WIDTH-1:0] w_mul_a;
  logic [WIDTH-1:0] w_mul_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_mul;

  // Sign-extended full-width product; the low 2*WIDTH bits equal the signed product.
  // The Q8.24 result is the product shifted down by FBITS and truncated to WIDTH bits.
  assign w_prod = {{WIDTH{w_mul_a[WIDTH-1]}}, w_mul_a} * {{WIDTH{w_mul_b[WIDTH-1]}}, w_mul_b};
  assign w_mul  = WIDTH'(w_prod >> FBITS);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one multiply per state, then hold in DONE until the result is taken
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_accept) w_next_state = S_MUL_Y2;
      S_MUL_Y2:    w_next_state = S_MUL_DELTA;
      S_MUL_DELTA: w_next_state = S_MUL_G;
      S_MUL_G:     w_next_state = S_MUL_W1;
      S_MUL_W1:    w_next_state = S_MUL_W2;
      S_MUL_W2:    w_next_state = S_MUL_P1;
      S_MUL_P1:    w_next_state = S_MUL_P2;
      S_MUL_P2:    w_next_state = S_DONE;
      S_DONE:      if (w_out_fire) w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  // Output/control logic: handshakes and the multiplier operand select for each state
  always_comb begin
    w_in_ready = (r_state == S_IDLE);
    w_accept   = in_valid && w_in_ready;
    w_out_fire = (r_state == S_DONE) && r_out_valid && out_ready;
    w_mul_a    = '0;
    w_mul_b    = '0;
    case (r_state)
      S_MUL_Y2: begin
        w_mul_a = r_y;
        w_mul_b = r_y;
      end
      S_MUL_DELTA: begin
        w_mul_a = r_e;
        w_mul_b = r_dy;
      end
      S_MUL_G: begin
        w_mul_a = r_lr;
        w_mul_b = r_delta;
      end
      S_MUL_W1: begin
        w_mul_a = r_g;
        w_mul_b = r_a1;
      end
      S_MUL_W2: begin
        w_mul_a = r_g;
        w_mul_b = r_a2;
      end
      S_MUL_P1: begin
        w_mul_a = r_delta;
        w_mul_b = r_w1;
      end
      S_MUL_P2: begin
        w_mul_a = r_delta;
        w_mul_b = r_w2;
      end
      default: begin
        w_mul_a = '0;
        w_mul_b = '0;
      end
    endcase
  end

  // Capture the operand bundle on accept so the inputs are free to change afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a1 <= '0;
      r_a2 <= '0;
      r_w1 <= '0;
      r_w2 <= '0;
      r_b  <= '0;
      r_y  <= '0;
      r_lr <= '0;
      r_e  <= '0;
    end else if (w_accept) begin
      r_a1 <= a_1;
      r_a2 <= a_2;
      r_w1 <= w_1;
      r_w2 <= w_2;
      r_b  <= b;
      r_y  <= y;
      r_lr <= lr;
      r_e  <= y - t;
    end
  end

  // Intermediate terms reused by later multiplies
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dy <= '0;
      r_g  <= '0;
    end else begin
      case (r_state)
        S_MUL_Y2: r_dy <= ONE - w_mul;
        S_MUL_G:  r_g  <= w_mul;
        default:  ;
      endcase
    end
  end

  // Result registers, each written once per bundle by its own FSM step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_delta  <= '0;
      r_b_new  <= '0;
      r_w1_new <= '0;
      r_w2_new <= '0;
      r_err1   <= '0;
      r_err2   <= '0;
    end else begin
      case (r_state)
        S_MUL_DELTA: r_delta  <= w_mul;
        S_MUL_G:     r_b_new  <= r_b - w_mul;
        S_MUL_W1:    r_w1_new <= r_w1 - w_mul;
        S_MUL_W2:    r_w2_new <= r_w2 - w_mul;
        S_MUL_P1:    r_err1   <= w_mul;
        S_MUL_P2:    r_err2   <= w_mul;
        default:     ;
      endcase
    end
  end

  // Result valid rises one edge after entering DONE and drops on the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_out_fire) begin
      r_out_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      r_out_valid <= 1'b1;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign delta     = r_delta;
  assign b_new     = r_b_new;
  assign w_1_new   = r_w1_new;
  assign w_2_new   = r_w2_new;
  assign err_1     = r_err1;
  assign err_2     = r_err2;

endmodule
